// File: rtl/matmul_controller.sv
// matmul_controller: sequences a DIMxDIM unsigned C = A x B over A/B read ports and a C write port.
// Define SAT_EN to saturate written results to 2^SIZE-1 instead of truncating them.
module matmul_controller #(
    parameter int DIM   = 2,
    parameter int SIZE  = 8,
    parameter int ACC_W = 2*SIZE+$clog2(DIM)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            abort_i,
    output logic            rd_a_en_o,
    output logic [5:0]      rd_a_addr_o,
    input  logic [SIZE-1:0] rd_a_data_i,
    output logic            rd_b_en_o,
    output logic [5:0]      rd_b_addr_o,
    input  logic [SIZE-1:0] rd_b_data_i,
    output logic            wr_c_en_o,
    output logic [5:0]      wr_c_addr_o,
    output logic [SIZE-1:0] wr_c_data_o,
    output logic            busy_o,
    output logic            done_o
);
    localparam int CW = DIM > 1 ? $clog2(DIM) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIM-1);

    typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    i_q, i_d, j_q, j_d, k_q, k_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [SIZE-1:0]  result;
    logic             mac, wr;

    assign mac = state_q == MAC;
    assign wr  = state_q == WRITE;

`ifdef SAT_EN
    assign result = acc_q > ACC_W'({SIZE{1'b1}}) ? {SIZE{1'b1}} : acc_q[SIZE-1:0];
`else
    assign result = acc_q[SIZE-1:0];
`endif

    // Everything visible is decoded from registered state, so reset forces all outputs to 0.
    assign rd_a_en_o   = mac;
    assign rd_b_en_o   = mac;
    assign rd_a_addr_o = mac ? 6'(int'(i_q)*DIM + int'(k_q)) : 6'd0;
    assign rd_b_addr_o = mac ? 6'(int'(k_q)*DIM + int'(j_q)) : 6'd0;
    assign wr_c_en_o   = wr;
    assign wr_c_addr_o = wr ? 6'(int'(i_q)*DIM + int'(j_q)) : 6'd0;
    assign wr_c_data_o = wr ? result : '0;
    assign busy_o      = mac || wr;
    assign done_o      = state_q == DONE;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        if (abort_i && (mac || wr)) begin
            state_d = IDLE;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            acc_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: if (start_i && !abort_i) begin
                    state_d = MAC;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end
                MAC: begin
                    acc_d   = acc_q + ACC_W'(rd_a_data_i) * ACC_W'(rd_b_data_i);
                    k_d     = k_q == LAST ? '0 : k_q + 1'b1;
                    state_d = k_q == LAST ? WRITE : MAC;
                end
                WRITE: begin
                    acc_d   = '0;
                    j_d     = j_q == LAST ? '0 : j_q + 1'b1;
                    i_d     = j_q != LAST ? i_q : i_q == LAST ? '0 : i_q + 1'b1;
                    state_d = (i_q == LAST && j_q == LAST) ? DONE : MAC;
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
        end
    end
endmodule

// File: tb/tb_matmul_controller.sv
// tb_matmul_controller: table, random and corner-case checks of the 2x2 matmul controller.
module tb_matmul_controller;
    logic       clk = 0, rst_n = 0, start = 0, abort = 0;
    logic       rd_a_en, rd_b_en, wr_c_en, busy, done;
    logic [5:0] rd_a_addr, rd_b_addr, wr_c_addr;
    logic [7:0] rd_a_data, rd_b_data, wr_c_data;
    logic [7:0] mem_a [64];
    logic [7:0] mem_b [64];
    logic [13:0] wq [$];
    int passed = 0, total = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c_trunc;
        logic [31:0] c_sat;
    } vec_t;
    vec_t vecs [5];

    matmul_controller dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .rd_a_en_o(rd_a_en), .rd_a_addr_o(rd_a_addr), .rd_a_data_i(rd_a_data),
        .rd_b_en_o(rd_b_en), .rd_b_addr_o(rd_b_addr), .rd_b_data_i(rd_b_data),
        .wr_c_en_o(wr_c_en), .wr_c_addr_o(wr_c_addr), .wr_c_data_o(wr_c_data),
        .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;
    assign rd_a_data = mem_a[rd_a_addr];
    assign rd_b_data = mem_b[rd_b_addr];
    always @(negedge clk) if (wr_c_en) wq.push_back({wr_c_addr, wr_c_data});

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else passed++;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] b);
        for (int n = 0; n < 64; n++) begin
            mem_a[n] = 8'd0;
            mem_b[n] = 8'd0;
        end
        for (int n = 0; n < 4; n++) begin
            mem_a[n] = a[8*n +: 8];
            mem_b[n] = b[8*n +: 8];
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r = 0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                int s = 0;
                for (int k = 0; k < 2; k++) s += int'(a[8*(i*2+k) +: 8]) * int'(b[8*(k*2+j) +: 8]);
`ifdef SAT_EN
                r[8*(i*2+j) +: 8] = 8'(s > 255 ? 255 : s);
`else
                r[8*(i*2+j) +: 8] = 8'(s % 256);
`endif
            end
        return r;
    endfunction

    // Start pulse, then watch 20 cycles; cycle 1 is the one right after the start edge.
    task automatic do_run(input int abort_at, output int done_cyc, output int busy_cyc);
        wq.delete();
        start = 1;
        @(negedge clk);
        start = 0;
        done_cyc = 0;
        busy_cyc = 0;
        for (int n = 1; n <= 20; n++) begin
            if (busy) busy_cyc++;
            if (done && done_cyc == 0) done_cyc = n;
            abort = (n == abort_at);
            @(negedge clk);
        end
        abort = 0;
    endtask

    task automatic check_writes(input string nm, input logic [31:0] exp);
        chk({nm, " write count"}, wq.size(), 4);
        for (int n = 0; n < wq.size() && n < 4; n++) begin
            chk($sformatf("%s addr[%0d]", nm, n), int'(wq[n][13:8]), n);
            chk($sformatf("%s data[%0d]", nm, n), int'(wq[n][7:0]), int'(exp[8*n +: 8]));
        end
    endtask

    initial begin
        int dc, bc, dn, first, b14, b15, strobes;
        logic [31:0] ra, rb;
        vecs[0] = '{32'h08070605, 32'h08070605, 32'h6A5B4E43, 32'h6A5B4E43};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h02020202, 32'hFFFFFFFF};
        vecs[2] = '{32'h01000001, 32'h06050403, 32'h06050403, 32'h06050403};
        vecs[3] = '{32'h03000002, 32'h281E140A, 32'h785A2814, 32'h785A2814};
        vecs[4] = '{32'h01001010, 32'h00090808, 32'h00098010, 32'h000980FF};
        load(vecs[0].a, vecs[0].b);
        repeat (2) @(negedge clk);
        chk("reset strobes", int'({rd_a_en, rd_b_en, wr_c_en, busy, done}), 0);
        chk("reset addrs", int'({rd_a_addr, rd_b_addr, wr_c_addr}), 0);
        chk("reset wdata", int'(wr_c_data), 0);
        rst_n = 1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            load(vecs[v].a, vecs[v].b);
            do_run(0, dc, bc);
`ifdef SAT_EN
            check_writes($sformatf("vec%0d", v), vecs[v].c_sat);
`else
            check_writes($sformatf("vec%0d", v), vecs[v].c_trunc);
`endif
            chk($sformatf("vec%0d done cycle", v), dc, 13);
            chk($sformatf("vec%0d busy cycles", v), bc, 12);
        end

        for (int r = 0; r < 20; r++) begin
            ra = $urandom;
            rb = $urandom;
            load(ra, rb);
            do_run(0, dc, bc);
            check_writes($sformatf("rand%0d", r), model(ra, rb));
            chk($sformatf("rand%0d done cycle", r), dc, 13);
        end

        load(vecs[0].a, vecs[0].b);
        do_run(4, dc, bc);
        chk("abort write count", wq.size(), 1);
        if (wq.size() > 0) chk("abort write data", int'(wq[0]), int'({6'd0, 8'd67}));
        chk("abort no done", dc, 0);
        chk("abort busy cycles", bc, 4);
        chk("abort idle after", int'(busy), 0);
        do_run(0, dc, bc);
        check_writes("post-abort", 32'h6A5B4E43);
        chk("post-abort done cycle", dc, 13);

        dn = 0;
        first = 0;
        b14 = -1;
        b15 = -1;
        start = 1;
        @(negedge clk);
        for (int n = 1; n <= 20; n++) begin
            if (done) begin
                dn++;
                if (first == 0) first = n;
            end
            if (n == 14) b14 = int'(busy);
            if (n == 15) b15 = int'(busy);
            @(negedge clk);
        end
        start = 0;
        chk("held start done cycle", first, 13);
        chk("held start done count", dn, 1);
        chk("held start idle gap", b14, 0);
        chk("held start rerun", b15, 1);
        abort = 1;
        @(negedge clk);
        abort = 0;
        @(negedge clk);

        wq.delete();
        start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("async rst strobes", int'({rd_a_en, rd_b_en, wr_c_en, busy, done}), 0);
        chk("async rst addrs", int'({rd_a_addr, rd_b_addr, wr_c_addr}), 0);
        @(negedge clk);
        rst_n = 1;
        repeat (15) @(negedge clk);
        chk("async rst no writes", wq.size(), 0);
        chk("async rst idle", int'(busy), 0);

        strobes = 0;
        start = 1;
        abort = 1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            strobes += int'(rd_a_en) + int'(rd_b_en) + int'(wr_c_en) + int'(busy) + int'(done);
        end
        start = 0;
        abort = 0;
        @(negedge clk);
        chk("start+abort strobes", strobes, 0);
        chk("start+abort busy", int'(busy), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
